// File: rtl/clk_ratio_sched_if.sv
// Configuration bus for clk_ratio_sched: valid/ready handshake carrying
// both divider half-periods, the sample point and the run length.
interface clk_ratio_sched_if #(
  parameter int CW = 8,
  parameter int EW = 16
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_div1;
  logic [CW-1:0] cfg_div2;
  logic [EW-1:0] cfg_sample;
  logic [EW-1:0] cfg_len;

  modport master (
    output cfg_valid, cfg_div1, cfg_div2, cfg_sample, cfg_len,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_div1, cfg_div2, cfg_sample, cfg_len,
    output cfg_ready
  );
endinterface

// File: rtl/clk_ratio_sched.sv
// Single-clock ratio scheduler: two programmable square waves with edge strobes,
// a bounded/unbounded run window and a one-shot level capture at a programmed cycle.
module clk_ratio_sched #(
  parameter int CW       = 8,
  parameter int EW       = 16,
  parameter int DIV1_RST = 5,
  parameter int DIV2_RST = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  clk_ratio_sched_if.slave       cfg,
  input  logic                   start_i,
  input  logic                   stop_i,
  output logic                   wave1_o,
  output logic                   wave2_o,
  output logic                   tick1_o,
  output logic                   tick2_o,
  output logic                   busy_o,
  output logic                   sample_valid_o,
  output logic [1:0]             sample_lvl_o,
  output logic                   done_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [EW-1:0] ONE_E  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] ZERO_E = {EW{1'b0}};
  localparam logic [EW-1:0] SAT_E  = {EW{1'b1}};

  // A zero half-period would never toggle; treat it as the fastest rate.
  function automatic logic [CW-1:0] fix_div(input logic [CW-1:0] d);
    fix_div = (d == ZERO_C) ? ONE_C : d;
  endfunction

  function automatic logic div_wrap(input logic [CW-1:0] cnt, input logic [CW-1:0] div);
    div_wrap = (cnt >= (div - ONE_C));
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] div1_q, div1_d, div2_q, div2_d;
  logic [EW-1:0] sample_q, sample_d, len_q, len_d;
  logic [EW-1:0] elapsed_q, elapsed_d;
  logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic          sampled_q, sampled_d;
  logic          wave1_q, wave1_d, wave2_q, wave2_d;
  logic          tick1_q, tick1_d, tick2_q, tick2_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          sample_valid_q, sample_valid_d;
  logic [1:0]    sample_lvl_q, sample_lvl_d;
  logic          cfg_ready_q, cfg_ready_d;

  logic          cfg_xfer_s;
  logic          last_cycle_s;
  logic          end_run_s;
  logic          wrap1_s, wrap2_s;

  // Next-state and registered-output computation for the whole scheduler.
  always_comb begin
    state_d        = state_q;
    div1_d         = div1_q;
    div2_d         = div2_q;
    sample_d       = sample_q;
    len_d          = len_q;
    elapsed_d      = elapsed_q;
    cnt1_d         = cnt1_q;
    cnt2_d         = cnt2_q;
    sampled_d      = sampled_q;
    wave1_d        = wave1_q;
    wave2_d        = wave2_q;
    tick1_d        = 1'b0;
    tick2_d        = 1'b0;
    busy_d         = busy_q;
    done_d         = 1'b0;
    sample_valid_d = 1'b0;
    sample_lvl_d   = sample_lvl_q;

    cfg_xfer_s   = cfg.cfg_valid && cfg_ready_q;
    last_cycle_s = (len_q != ZERO_E) && (elapsed_q == (len_q - ONE_E));
    end_run_s    = (state_q == S_RUN) && (stop_i || last_cycle_s);
    wrap1_s      = div_wrap(cnt1_q, div1_q);
    wrap2_s      = div_wrap(cnt2_q, div2_q);

    case (state_q)
      S_IDLE: begin
        wave1_d = 1'b0;
        wave2_d = 1'b0;
        // Config lands before the run starts, so a same-cycle start sees it.
        if (cfg_xfer_s) begin
          div1_d   = fix_div(cfg.cfg_div1);
          div2_d   = fix_div(cfg.cfg_div2);
          sample_d = cfg.cfg_sample;
          len_d    = cfg.cfg_len;
        end else begin
          div1_d   = div1_q;
        end
        if (start_i) begin
          state_d   = S_RUN;
          busy_d    = 1'b1;
          elapsed_d = ZERO_E;
          cnt1_d    = ZERO_C;
          cnt2_d    = ZERO_C;
          sampled_d = 1'b0;
        end else begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
        end
      end

      S_RUN: begin
        // Capture precedes end handling so the final RUN cycle can still sample.
        if (!sampled_q && (elapsed_q == sample_q)) begin
          sample_valid_d = 1'b1;
          sample_lvl_d   = {wave2_q, wave1_q};
          sampled_d      = 1'b1;
        end else begin
          sample_valid_d = 1'b0;
        end

        if (end_run_s) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          wave1_d   = 1'b0;
          wave2_d   = 1'b0;
          elapsed_d = ZERO_E;
          cnt1_d    = ZERO_C;
          cnt2_d    = ZERO_C;
        end else begin
          state_d   = S_RUN;
          busy_d    = 1'b1;
          elapsed_d = (elapsed_q == SAT_E) ? SAT_E : (elapsed_q + ONE_E);
          if (wrap1_s) begin
            cnt1_d  = ZERO_C;
            wave1_d = ~wave1_q;
            tick1_d = 1'b1;
          end else begin
            cnt1_d  = cnt1_q + ONE_C;
          end
          if (wrap2_s) begin
            cnt2_d  = ZERO_C;
            wave2_d = ~wave2_q;
            tick2_d = 1'b1;
          end else begin
            cnt2_d  = cnt2_q + ONE_C;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        wave1_d = 1'b0;
        wave2_d = 1'b0;
      end
    endcase

    cfg_ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      div1_q         <= CW'(DIV1_RST);
      div2_q         <= CW'(DIV2_RST);
      sample_q       <= ZERO_E;
      len_q          <= ZERO_E;
      elapsed_q      <= ZERO_E;
      cnt1_q         <= ZERO_C;
      cnt2_q         <= ZERO_C;
      sampled_q      <= 1'b0;
      wave1_q        <= 1'b0;
      wave2_q        <= 1'b0;
      tick1_q        <= 1'b0;
      tick2_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_lvl_q   <= 2'b00;
      cfg_ready_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      div1_q         <= div1_d;
      div2_q         <= div2_d;
      sample_q       <= sample_d;
      len_q          <= len_d;
      elapsed_q      <= elapsed_d;
      cnt1_q         <= cnt1_d;
      cnt2_q         <= cnt2_d;
      sampled_q      <= sampled_d;
      wave1_q        <= wave1_d;
      wave2_q        <= wave2_d;
      tick1_q        <= tick1_d;
      tick2_q        <= tick2_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      sample_valid_q <= sample_valid_d;
      sample_lvl_q   <= sample_lvl_d;
      cfg_ready_q    <= cfg_ready_d;
    end
  end

  assign cfg.cfg_ready    = cfg_ready_q;
  assign wave1_o          = wave1_q;
  assign wave2_o          = wave2_q;
  assign tick1_o          = tick1_q;
  assign tick2_o          = tick2_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign sample_valid_o   = sample_valid_q;
  assign sample_lvl_o     = sample_lvl_q;

endmodule

// File: tb/tb_clk_ratio_sched.sv
// Directed bench for clk_ratio_sched: a table of runs checked cycle by cycle
// against the closed-form wave definition, plus hand-written corner sequences.
module tb_clk_ratio_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       wave1, wave2, tick1, tick2, busy, sample_valid, done;
  logic [1:0] sample_lvl;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [1:0] last_lvl = 2'b00;

  clk_ratio_sched_if #(.CW(8), .EW(16)) cfg_if ();

  clk_ratio_sched #(.CW(8), .EW(16), .DIV1_RST(5), .DIV2_RST(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg            (cfg_if.slave),
    .start_i        (start),
    .stop_i         (stop),
    .wave1_o        (wave1),
    .wave2_o        (wave2),
    .tick1_o        (tick1),
    .tick2_o        (tick2),
    .busy_o         (busy),
    .sample_valid_o (sample_valid),
    .sample_lvl_o   (sample_lvl),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         d1;
    int         d2;
    int         s;
    int         len;
    int         stop_at;
    logic       exp_sv;
    logic [1:0] lvl;
  } vec_t;

  vec_t tbl [8];

  // Packed view: {wave1, wave2, tick1, tick2, busy, done, sample_valid, cfg_ready}
  function automatic logic [7:0] act_bits();
    return {wave1, wave2, tick1, tick2, busy, done, sample_valid, cfg_if.cfg_ready};
  endfunction

  function automatic logic [7:0] exp_run(int n, int d1, int d2, logic sv);
    logic w1, w2, t1, t2;
    w1 = ((n / d1) % 2) == 1;
    w2 = ((n / d2) % 2) == 1;
    t1 = (n > 0) && ((n % d1) == 0);
    t2 = (n > 0) && ((n % d2) == 0);
    return {w1, w2, t1, t2, 1'b1, 1'b0, sv, 1'b0};
  endfunction

  function automatic logic [7:0] exp_idle(logic dn, logic sv);
    return {4'b0000, 1'b0, dn, sv, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int d1, input int d2, input int s, input int len);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_div1   = 8'(d1);
    cfg_if.cfg_div2   = 8'(d2);
    cfg_if.cfg_sample = 16'(s);
    cfg_if.cfg_len    = 16'(len);
  endtask

  // Issues start now (caller is just past a falling edge) and checks every cycle.
  task automatic run_and_check(input int d1, input int d2, input int s, input int len,
                               input int stop_at, input logic exp_sv,
                               input logic [1:0] exp_lvl, input string tag);
    int   e1, e2, end_n;
    logic sv;
    e1 = (d1 == 0) ? 1 : d1;
    e2 = (d2 == 0) ? 1 : d2;
    if (stop_at >= 0 && (len == 0 || stop_at < len)) end_n = stop_at + 1;
    else end_n = len;
    start = 1'b1;
    for (int n = 0; n <= end_n + 1; n++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      sv = exp_sv && (n == s + 1);
      if (n < end_n) chk($sformatf("%s.run[%0d]", tag, n), act_bits(), exp_run(n, e1, e2, sv));
      else chk($sformatf("%s.idle[%0d]", tag, n), act_bits(), exp_idle(n == end_n, sv));
      if (sv) chk($sformatf("%s.lvl", tag), {6'b0, sample_lvl}, {6'b0, exp_lvl});
      if (n == stop_at) stop = 1'b1;
    end
    if (exp_sv) last_lvl = exp_lvl;
    chk($sformatf("%s.hold", tag), {6'b0, sample_lvl}, {6'b0, last_lvl});
  endtask

  initial begin
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_div1   = 8'd0;
    cfg_if.cfg_div2   = 8'd0;
    cfg_if.cfg_sample = 16'd0;
    cfg_if.cfg_len    = 16'd0;

    //          d1   d2   s    len  stop exp_sv lvl
    tbl[0] = '{ 5,  10,  80,   0,  90, 1'b1, 2'b00};
    tbl[1] = '{ 5,  10,  85, 100,  -1, 1'b1, 2'b01};
    tbl[2] = '{ 0,   1,   3,   4,  -1, 1'b1, 2'b11};
    tbl[3] = '{ 2,   3,  50,   0,   3, 1'b0, 2'b00};
    tbl[4] = '{ 3,   4,  60,   6,   5, 1'b0, 2'b00};
    tbl[5] = '{ 7,   2,   0,  10,  -1, 1'b1, 2'b00};
    tbl[6] = '{255,  1, 256, 300,  -1, 1'b1, 2'b01};
    tbl[7] = '{ 4,   6,  11,  12,  -1, 1'b1, 2'b10};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset.in", act_bits(), exp_idle(1'b0, 1'b0));
    rst = 1'b0;
    @(negedge clk);
    chk("reset.out", act_bits(), exp_idle(1'b0, 1'b0));
    chk("reset.lvl", {6'b0, sample_lvl}, 8'h00);

    // Table: config transfer issued together with start
    for (int i = 0; i < 8; i++) begin
      set_cfg(tbl[i].d1, tbl[i].d2, tbl[i].s, tbl[i].len);
      run_and_check(tbl[i].d1, tbl[i].d2, tbl[i].s, tbl[i].len, tbl[i].stop_at,
                    tbl[i].exp_sv, tbl[i].lvl, $sformatf("vec%0d", i));
    end

    // Stop in IDLE is ignored
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle_stop", act_bits(), exp_idle(1'b0, 1'b0));

    // Config held off during RUN, start in RUN ignored, transfer once IDLE
    set_cfg(5, 10, 200, 0);
    start = 1'b1;
    for (int n = 0; n <= 5; n++) begin
      @(negedge clk);
      start = (n == 3);
      if (n == 0) cfg_if.cfg_valid = 1'b0;
      chk($sformatf("held.run[%0d]", n), act_bits(), exp_run(n, 5, 10, 1'b0));
      if (n == 1) set_cfg(2, 3, 5, 8);
      if (n == 5) stop = 1'b1;
    end
    @(negedge clk);
    stop = 1'b0;
    chk("held.done", act_bits(), exp_idle(1'b1, 1'b0));
    @(negedge clk);
    chk("held.idle", act_bits(), exp_idle(1'b0, 1'b0));
    cfg_if.cfg_valid = 1'b0;
    run_and_check(2, 3, 5, 8, -1, 1'b1, 2'b10, "held.new");

    // Reset mid-run before the sample point
    set_cfg(3, 4, 25, 0);
    start = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      chk($sformatf("rst.run[%0d]", n), act_bits(), exp_run(n, 3, 4, 1'b0));
      if (n == 20) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("rst.after", act_bits(), exp_idle(1'b0, 1'b0));
    chk("rst.lvl", {6'b0, sample_lvl}, 8'h00);
    last_lvl = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rst.quiet[%0d]", k), act_bits(), exp_idle(1'b0, 1'b0));
    end
    // Defaults restored: divs 5/10, sample 0, len 0
    run_and_check(5, 10, 0, 0, 12, 1'b1, 2'b00, "rst.dflt");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
